// File: rtl/fp_to_int_seq.sv
// Sequential floating-point to integer converter: bit-serial integer extraction
// followed by optional rounding, saturation and sign-magnitude / two's complement output.
module fp_to_int_seq #(
    parameter int EXP_W     = 4,
    parameter int FRAC_W    = 8,
    parameter int INT_W     = 8,
    parameter bit TWOS_COMP = 1'b0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              sign,
    input  logic [EXP_W-1:0]  exp,
    input  logic [FRAC_W-1:0] frac,
    input  logic              rnd_en,
    input  logic              sat_en,
    output logic              ready,
    output logic              done,
    output logic [INT_W-1:0]  integ,
    output logic              uf,
    output logic              of
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_FIN   = 2'd2;

    localparam logic [INT_W-1:0] MAX_MAG = {1'b0, {(INT_W-1){1'b1}}};

    logic [1:0]        state_q,   state_d;
    logic              sign_q,    sign_d;
    logic              rnd_q,     rnd_d;
    logic              sat_q,     sat_d;
    logic              uf_pend_q, uf_pend_d;
    logic              of_pend_q, of_pend_d;
    logic [EXP_W-1:0]  cnt_q,     cnt_d;
    logic [INT_W-2:0]  acc_q,     acc_d;
    logic [FRAC_W-1:0] fr_q,      fr_d;
    logic [INT_W-1:0]  integ_q,   integ_d;
    logic              uf_q,      uf_d;
    logic              of_q,      of_d;
    logic              done_q,    done_d;

    // Finishing arithmetic, only consumed while in FIN.
    logic [INT_W-1:0] mag;
    logic [INT_W-1:0] sel_mag;
    logic [INT_W-1:0] fmt;
    logic             ovf;

    always_comb begin
        mag     = {1'b0, acc_q} + INT_W'(rnd_q & fr_q[FRAC_W-1]);
        ovf     = of_pend_q | (mag > MAX_MAG);
        sel_mag = ovf ? (sat_q ? MAX_MAG : '0) : mag;
        if (sel_mag == '0) begin
            fmt = '0;
        end else if (TWOS_COMP) begin
            fmt = sign_q ? (~sel_mag + 1'b1) : sel_mag;
        end else begin
            fmt = {sign_q, sel_mag[INT_W-2:0]};
        end
    end

    // NOTE: every _d gets a default before the case so no path leaves it unassigned (no latches).
    always_comb begin
        state_d   = state_q;
        sign_d    = sign_q;
        rnd_d     = rnd_q;
        sat_d     = sat_q;
        uf_pend_d = uf_pend_q;
        of_pend_d = of_pend_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        fr_d      = fr_q;
        integ_d   = integ_q;
        uf_d      = uf_q;
        of_d      = of_q;
        done_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    sign_d    = sign;
                    rnd_d     = rnd_en;
                    sat_d     = sat_en;
                    uf_pend_d = 1'b0;
                    of_pend_d = 1'b0;
                    cnt_d     = '0;
                    acc_d     = '0;
                    fr_d      = '0;
                    if (!frac[FRAC_W-1]) begin
                        state_d = S_FIN;
                    end else if (exp == '0) begin
                        uf_pend_d = 1'b1;
                        state_d   = S_FIN;
                    end else if (exp > EXP_W'(INT_W-1)) begin
                        of_pend_d = 1'b1;
                        state_d   = S_FIN;
                    end else begin
                        cnt_d   = exp;
                        fr_d    = frac;
                        state_d = S_SHIFT;
                    end
                end
            end
            S_SHIFT: begin
                acc_d = {acc_q[INT_W-3:0], fr_q[FRAC_W-1]};
                fr_d  = {fr_q[FRAC_W-2:0], 1'b0};
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == EXP_W'(1)) state_d = S_FIN;
            end
            S_FIN: begin
                integ_d = fmt;
                uf_d    = uf_pend_q;
                of_d    = ovf;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state uses non-blocking assignments so all flops update from pre-edge values.
    // NOTE: every register, datapath included, is reset so an aborted conversion leaves no residue.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            sign_q    <= 1'b0;
            rnd_q     <= 1'b0;
            sat_q     <= 1'b0;
            uf_pend_q <= 1'b0;
            of_pend_q <= 1'b0;
            cnt_q     <= '0;
            acc_q     <= '0;
            fr_q      <= '0;
            integ_q   <= '0;
            uf_q      <= 1'b0;
            of_q      <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            sign_q    <= sign_d;
            rnd_q     <= rnd_d;
            sat_q     <= sat_d;
            uf_pend_q <= uf_pend_d;
            of_pend_q <= of_pend_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            fr_q      <= fr_d;
            integ_q   <= integ_d;
            uf_q      <= uf_d;
            of_q      <= of_d;
            done_q    <= done_d;
        end
    end

    assign ready = (state_q == S_IDLE);
    assign done  = done_q;
    assign integ = integ_q;
    assign uf    = uf_q;
    assign of    = of_q;

endmodule

// File: tb/tb_fp_to_int_seq.sv
// Bench for fp_to_int_seq: sign-magnitude and two's complement instances share stimulus,
// checked against directed vectors and an arithmetic reference model.
module tb_fp_to_int_seq;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       start = 1'b0;
    logic       sign = 1'b0;
    logic [3:0] exp = '0;
    logic [7:0] frac = '0;
    logic       rnd_en = 1'b0;
    logic       sat_en = 1'b0;

    logic       ready_sm, done_sm, uf_sm, of_sm;
    logic       ready_tc, done_tc, uf_tc, of_tc;
    logic [7:0] integ_sm, integ_tc;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    fp_to_int_seq #(.EXP_W(4), .FRAC_W(8), .INT_W(8), .TWOS_COMP(1'b0)) u_sm (
        .clk(clk), .reset_n(reset_n), .start(start), .sign(sign), .exp(exp), .frac(frac),
        .rnd_en(rnd_en), .sat_en(sat_en), .ready(ready_sm), .done(done_sm),
        .integ(integ_sm), .uf(uf_sm), .of(of_sm));

    fp_to_int_seq #(.EXP_W(4), .FRAC_W(8), .INT_W(8), .TWOS_COMP(1'b1)) u_tc (
        .clk(clk), .reset_n(reset_n), .start(start), .sign(sign), .exp(exp), .frac(frac),
        .rnd_en(rnd_en), .sat_en(sat_en), .ready(ready_tc), .done(done_tc),
        .integ(integ_tc), .uf(uf_tc), .of(of_tc));

    typedef struct {
        logic       sign;
        logic [3:0] exp;
        logic [7:0] frac;
        logic       rnd;
        logic       sat;
        logic [7:0] sm;
        logic [7:0] tc;
        logic       uf;
        logic       of;
        int         lat;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Reference: value = frac * 2^exp / 2^8, integer part plus the half bit.
    function automatic vec_t model(input logic s, input logic [3:0] e, input logic [7:0] f,
                                   input logic rnd, input logic sat);
        vec_t   r;
        longint scaled, ip, m;
        r.sign = s; r.exp = e; r.frac = f; r.rnd = rnd; r.sat = sat;
        r.uf = 1'b0; r.of = 1'b0; m = 0;
        if (f < 8'd128) begin
            r.lat = 1;
        end else if (e == 0) begin
            r.uf = 1'b1; r.lat = 1;
        end else if (e > 7) begin
            r.of = 1'b1; r.lat = 1;
        end else begin
            r.lat  = int'(e) + 1;
            scaled = longint'(f) * (longint'(1) << e);
            ip     = scaled / 256;
            m      = ip + ((rnd && ((scaled / 128) % 2 == 1)) ? 1 : 0);
            if (m > 127) r.of = 1'b1;
        end
        if (r.of) m = sat ? 127 : 0;
        r.sm = (s && m != 0) ? 8'(128 + m) : 8'(m);
        r.tc = s ? 8'(256 - m) : 8'(m);
        return r;
    endfunction

    task automatic drive(input vec_t v);
        sign = v.sign; exp = v.exp; frac = v.frac; rnd_en = v.rnd; sat_en = v.sat;
    endtask

    // Waits (bounded) for done, counting edges from the accepting edge already taken.
    task automatic wait_check(input vec_t v, input string tag, input int k0);
        int k = k0;
        do begin
            @(posedge clk); #1; k++;
        end while (!done_sm && k < 40);
        check({tag, " latency"}, k, v.lat);
        check({tag, " done_tc"}, done_tc, 1'b1);
        check({tag, " integ_sm"}, integ_sm, v.sm);
        check({tag, " integ_tc"}, integ_tc, v.tc);
        check({tag, " uf"}, {uf_sm, uf_tc}, {v.uf, v.uf});
        check({tag, " of"}, {of_sm, of_tc}, {v.of, v.of});
        check({tag, " ready"}, {ready_sm, ready_tc}, 2'b11);
    endtask

    task automatic run_conv(input vec_t v, input string tag);
        drive(v);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_check(v, tag, 0);
    endtask

    initial begin
        vec_t tbl[12];
        vec_t v, w;

        tbl[0]  = '{1'b0, 4'd3, 8'hB0, 1'b0, 1'b0, 8'h05, 8'h05, 1'b0, 1'b0, 4};
        tbl[1]  = '{1'b0, 4'd3, 8'hB0, 1'b1, 1'b0, 8'h06, 8'h06, 1'b0, 1'b0, 4};
        tbl[2]  = '{1'b1, 4'd4, 8'hC0, 1'b0, 1'b0, 8'h8C, 8'hF4, 1'b0, 1'b0, 5};
        tbl[3]  = '{1'b0, 4'd0, 8'h80, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1};
        tbl[4]  = '{1'b0, 4'd5, 8'h40, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1};
        tbl[5]  = '{1'b1, 4'd9, 8'h80, 1'b0, 1'b1, 8'hFF, 8'h81, 1'b0, 1'b1, 1};
        tbl[6]  = '{1'b1, 4'd9, 8'h80, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1};
        tbl[7]  = '{1'b0, 4'd7, 8'hFF, 1'b0, 1'b0, 8'h7F, 8'h7F, 1'b0, 1'b0, 8};
        tbl[8]  = '{1'b0, 4'd7, 8'hFF, 1'b1, 1'b1, 8'h7F, 8'h7F, 1'b0, 1'b1, 8};
        tbl[9]  = '{1'b0, 4'd7, 8'hFF, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 8};
        tbl[10] = '{1'b1, 4'd7, 8'hFF, 1'b1, 1'b1, 8'hFF, 8'h81, 1'b0, 1'b1, 8};
        tbl[11] = '{1'b1, 4'd1, 8'h80, 1'b1, 1'b0, 8'h81, 8'hFF, 1'b0, 1'b0, 2};

        #2;
        check("reset ready", {ready_sm, ready_tc}, 2'b11);
        check("reset outputs", {done_sm, integ_sm, uf_sm, of_sm, integ_tc, uf_tc, of_tc}, '0);
        @(negedge clk); reset_n = 1'b1;
        @(posedge clk); #1;

        // Back-to-back: each vector starts in the done cycle of the previous one.
        for (int i = 0; i < 12; i++) run_conv(tbl[i], $sformatf("vec%0d", i));

        // Starts during SHIFT are ignored.
        drive(tbl[0]);
        start = 1'b1;
        @(posedge clk); #1;
        drive(tbl[2]);
        check("busy ready", ready_sm, 1'b0);
        @(posedge clk); #1;
        start = 1'b0;
        drive(tbl[5]);
        wait_check(tbl[0], "ignored_start", 1);

        // Start in the done cycle is accepted.
        check("done-cycle ready", {done_sm, ready_sm}, 2'b11);
        run_conv(tbl[2], "done_cycle_start");

        // Reset mid-SHIFT aborts the conversion.
        drive(tbl[7]);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        reset_n = 1'b0;
        #1;
        check("abort ready", {ready_sm, ready_tc}, 2'b11);
        check("abort outputs", {done_sm, integ_sm, uf_sm, of_sm, integ_tc, uf_tc, of_tc}, '0);
        @(negedge clk); reset_n = 1'b1;
        begin
            int seen = 0;
            for (int c = 0; c < 12; c++) begin
                @(posedge clk); #1;
                if (done_sm || done_tc) seen++;
            end
            check("abort no done", seen, 0);
        end

        // Random operands against the reference model.
        for (int i = 0; i < 300; i++) begin
            logic [7:0] f;
            f = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 7) != 0) f[7] = 1'b1;
            w = model(1'($urandom_range(0, 1)), 4'($urandom_range(0, 9)), f,
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
            end
            run_conv(w, $sformatf("rand%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
